// File: rtl/awg_pkg.sv
// Shared types and defaults for the AWG trigger dispatcher: FSM states,
// bus idle select, watchdog defaults and the queued command word layout.
package awg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_SETUP,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [3:0]  IDLE_SEL_DEF    = 4'hF;
  localparam int unsigned ACK_TIMEOUT_DEF = 4;
  localparam logic [23:0] RUN_TIMEOUT_DEF = 24'd10_000_000;
  localparam int unsigned GAP_CYCLES_DEF  = 2;

  localparam int unsigned CMD_W = 20;

  typedef struct packed {
    logic [3:0]  brd;
    logic [15:0] addr;
  } cmd_t;

endpackage

// File: rtl/awg_cmd_fifo.sv
// Synchronous command FIFO; a push alongside a pop is accepted even when full,
// so a refill on the dispatch cycle never loses a slot.
module awg_cmd_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 20
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o  = r_count[AW];
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign rdata_o = r_mem[r_rd_ptr];
  assign count_o = r_count;

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/awg_trigger_dispatcher.sv
// Queues host run requests and dispatches them one at a time onto the shared
// AWG sel/addr/start bus, tracking each board's ready handshake with watchdogs.
module awg_trigger_dispatcher
  import awg_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [3:0]  IDLE_SEL    = IDLE_SEL_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter logic [23:0] RUN_TIMEOUT = RUN_TIMEOUT_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cmd_valid_i,
  input  logic [3:0]         cmd_brd_i,
  input  logic [15:0]        cmd_addr_i,
  output logic               cmd_ready_o,
  input  logic               ext_mode_i,
  input  logic               ext_trig_i,
  output logic [3:0]         sel_o,
  output logic [15:0]        addr_o,
  output logic               start_trig_o,
  input  logic               ready_i,
  output logic               awg_abort_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   fifo_count_o,
  output logic [15:0]        done_count_o,
  output logic               nack_o,
  output logic               timeout_o
);

  localparam logic [23:0] ACK_LAST = 24'(ACK_TIMEOUT - 1);
  localparam logic [23:0] RUN_LAST = RUN_TIMEOUT - 24'd1;
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_cnt;
  logic [3:0]  r_brd;
  logic [15:0] r_addr;
  logic        r_trig_prev;
  logic [15:0] r_done_cnt;
  logic        r_nack;
  logic        r_tmo;
  logic        r_abort;

  cmd_t        w_cmd_in;
  cmd_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_cnt_clr;
  logic        w_done_inc;
  logic        w_nack_set;
  logic        w_tmo_set;
  logic        w_trig_rise;
  logic        w_bus_run;

  assign w_cmd_in = '{brd: cmd_brd_i, addr: cmd_addr_i};

  awg_cmd_fifo #(
    .AW (FIFO_AW),
    .DW (CMD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_valid_i),
    .pop_i   (w_pop),
    .wdata_i (w_cmd_in),
    .rdata_o (w_head),
    .count_o (fifo_count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_trig_rise = ext_trig_i && !r_trig_prev;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cnt_clr   = 1'b0;
    w_done_inc  = 1'b0;
    w_nack_set  = 1'b0;
    w_tmo_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ext_mode_i ? S_WAIT_TRIG : S_SETUP;
        end
      end
      S_WAIT_TRIG: if (w_trig_rise) w_state_nxt = S_SETUP;
      S_SETUP:     w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_state_nxt = S_WAIT_ACK;
        w_cnt_clr   = 1'b1;
      end
      S_WAIT_ACK: begin
        if (!ready_i) begin
          w_state_nxt = S_WAIT_DONE;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == ACK_LAST) begin
          w_nack_set  = 1'b1;
          w_state_nxt = S_GAP;
          w_cnt_clr   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (ready_i) begin
          w_done_inc  = 1'b1;
          w_state_nxt = S_GAP;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == RUN_LAST) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_GAP;
          w_cnt_clr   = 1'b1;
        end
      end
      S_GAP:   if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_brd       <= IDLE_SEL;
      r_addr      <= '0;
      r_trig_prev <= 1'b0;
      r_done_cnt  <= '0;
      r_nack      <= 1'b0;
      r_tmo       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_trig_prev <= ext_trig_i;
      r_cnt       <= (w_cnt_clr || r_state == S_IDLE) ? '0 : r_cnt + 24'd1;
      if (w_pop) begin
        r_brd  <= w_head.brd;
        r_addr <= w_head.addr;
      end
      if (w_done_inc) r_done_cnt <= r_done_cnt + 16'd1;
      if (w_nack_set) r_nack <= 1'b1;
      if (w_tmo_set)  r_tmo  <= 1'b1;
      r_abort <= w_tmo_set;
    end
  end

  // The AWG muxes its outputs on sel, so sel is only released outside a run.
  assign w_bus_run = (r_state == S_SETUP) || (r_state == S_ISSUE) ||
                     (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE);

  assign sel_o        = w_bus_run ? r_brd : IDLE_SEL;
  assign addr_o       = r_addr;
  assign start_trig_o = (r_state == S_ISSUE);
  assign awg_abort_o  = r_abort;
  assign cmd_ready_o  = !w_full;
  assign busy_o       = (r_state != S_IDLE) || !w_empty;
  assign done_count_o = r_done_cnt;
  assign nack_o       = r_nack;
  assign timeout_o    = r_tmo;

endmodule

// File: tb/tb_awg_trigger_dispatcher.sv
// Directed bench for awg_trigger_dispatcher with a behavioural AWG ready model;
// samples and drives on the falling edge.
`timescale 1ns/1ps
module tb_awg_trigger_dispatcher;

  typedef enum int {RSP_NORMAL, RSP_STUCK_HI, RSP_STUCK_LO} rsp_mode_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_valid_i;
  logic [3:0]  cmd_brd_i;
  logic [15:0] cmd_addr_i;
  logic        cmd_ready_o;
  logic        ext_mode_i;
  logic        ext_trig_i;
  logic [3:0]  sel_o;
  logic [15:0] addr_o;
  logic        start_trig_o;
  logic        ready_i;
  logic        awg_abort_o;
  logic        busy_o;
  logic [4:0]  fifo_count_o;
  logic [15:0] done_count_o;
  logic        nack_o;
  logic        timeout_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_start  = 0;
  int          n_abort  = 0;
  logic [15:0] addr_q[$];
  rsp_mode_t   rsp_mode = RSP_NORMAL;
  int          run_len  = 20;
  int          rsp_cnt  = 0;

  awg_trigger_dispatcher #(
    .FIFO_AW     (4),
    .IDLE_SEL    (4'hF),
    .ACK_TIMEOUT (4),
    .RUN_TIMEOUT (24'd100),
    .GAP_CYCLES  (2)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_brd_i    (cmd_brd_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_ready_o  (cmd_ready_o),
    .ext_mode_i   (ext_mode_i),
    .ext_trig_i   (ext_trig_i),
    .sel_o        (sel_o),
    .addr_o       (addr_o),
    .start_trig_o (start_trig_o),
    .ready_i      (ready_i),
    .awg_abort_o  (awg_abort_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o),
    .done_count_o (done_count_o),
    .nack_o       (nack_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic push(input logic [3:0] b, input logic [15:0] a);
    cmd_valid_i = 1'b1;
    cmd_brd_i   = b;
    cmd_addr_i  = a;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start_trig_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, start_trig_o, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy_o && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, busy_o, 0);
  endtask

  // AWG ready model: drops ready on the start cycle, raises it run_len cycles later.
  initial begin
    forever begin
      @(negedge clk_i);
      if (start_trig_o && rsp_mode != RSP_STUCK_HI) begin
        ready_i = 1'b0;
        rsp_cnt = run_len;
      end else if (rsp_mode == RSP_NORMAL && !ready_i) begin
        rsp_cnt--;
        if (rsp_cnt <= 0) ready_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (start_trig_o) begin
        n_start++;
        addr_q.push_back(addr_o);
      end
      if (awg_abort_o) n_abort++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          base_start;
    int          base_abort;
    logic [15:0] base_done;
    bit          ok;
    int          n;
    logic [15:0] exp_addr;
    logic [31:0] got;

    reset_i     = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_brd_i   = '0;
    cmd_addr_i  = '0;
    ext_mode_i  = 1'b0;
    ext_trig_i  = 1'b0;
    ready_i     = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_sel", sel_o, 4'hF);
    check("rst_addr", addr_o, 0);
    check("rst_start", start_trig_o, 0);
    check("rst_abort", awg_abort_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_done", done_count_o, 0);
    check("rst_flags", {nack_o, timeout_o}, 0);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_busy", busy_o, 0);
    reset_i = 1'b0;
    tick();

    // Single run, internal mode: push N, pop N+1, sel N+2, start N+3
    base_start = n_start;
    run_len    = 20;
    push(4'd2, 16'h0040);
    check("t1_count_after_push", fifo_count_o, 1);
    check("t1_sel_before_setup", sel_o, 4'hF);
    tick();
    check("t1_setup_sel", sel_o, 4'd2);
    check("t1_setup_addr", addr_o, 16'h0040);
    check("t1_setup_start", start_trig_o, 0);
    tick();
    check("t1_issue_start", start_trig_o, 1);
    check("t1_issue_sel", sel_o, 4'd2);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel_o !== 4'd2 || addr_o !== 16'h0040 || start_trig_o !== 1'b0) ok = 1'b0;
    end
    check("t1_bus_stable", ok, 1);
    tick();
    check("t1_gap1_sel", sel_o, 4'hF);
    check("t1_done", done_count_o, 1);
    tick();
    check("t1_gap2_sel", sel_o, 4'hF);
    tick();
    check("t1_idle_busy", busy_o, 0);
    check("t1_one_start", n_start - base_start, 1);

    // External mode: no start without an edge, start two cycles after it
    base_start = n_start;
    run_len    = 5;
    ext_mode_i = 1'b1;
    push(4'd5, 16'h0500);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (start_trig_o !== 1'b0) ok = 1'b0;
    end
    check("t3_no_start_without_edge", ok, 1);
    check("t3_busy_waiting", busy_o, 1);
    ext_trig_i = 1'b1;
    tick();
    check("t3_edge_plus1_start", start_trig_o, 0);
    check("t3_edge_plus1_sel", sel_o, 4'd5);
    tick();
    check("t3_edge_plus2_start", start_trig_o, 1);
    ext_trig_i = 1'b0;
    ext_mode_i = 1'b0;
    wait_idle("t3_idle", 200);
    check("t3_done", done_count_o, 2);

    // Acknowledge timeout: ready never falls
    base_start = n_start;
    base_abort = n_abort;
    base_done  = done_count_o;
    rsp_mode   = RSP_STUCK_HI;
    push(4'd3, 16'h0300);
    push(4'd4, 16'h0400);
    wait_start("t4a_start");
    repeat (4) tick();
    check("t4_nack_before", nack_o, 0);
    tick();
    check("t4_nack_after", nack_o, 1);
    wait_start("t4b_start");
    check("t4b_addr", addr_o, 16'h0400);
    wait_idle("t4_idle", 200);
    check("t4_starts", n_start - base_start, 2);
    check("t4_no_abort", n_abort - base_abort, 0);
    check("t4_done_unchanged", done_count_o, base_done);

    // Run timeout: ready falls and never returns (RUN_TIMEOUT=100)
    base_abort = n_abort;
    base_done  = done_count_o;
    rsp_mode   = RSP_STUCK_LO;
    push(4'd6, 16'h0600);
    wait_start("t5_start");
    ok = 1'b1;
    for (int i = 0; i < 101; i++) begin
      tick();
      if (awg_abort_o !== 1'b0) ok = 1'b0;
    end
    check("t5_no_early_abort", ok, 1);
    check("t5_tmo_before", timeout_o, 0);
    tick();
    check("t5_abort_pulse", awg_abort_o, 1);
    check("t5_tmo_after", timeout_o, 1);
    tick();
    check("t5_abort_single", awg_abort_o, 0);
    wait_idle("t5_idle", 200);
    check("t5_abort_count", n_abort - base_abort, 1);
    check("t5_done_unchanged", done_count_o, base_done);
    rsp_mode = RSP_NORMAL;
    ready_i  = 1'b1;
    tick();

    // FIFO full, dropped push and push-during-pop at full
    addr_q.delete();
    run_len = 40;
    push(4'd1, 16'h0A00);
    tick();
    check("t2_head_popped", fifo_count_o, 0);
    for (int i = 0; i < 17; i++) begin
      cmd_valid_i = 1'b1;
      cmd_brd_i   = 4'(i % 8);
      cmd_addr_i  = 16'h1000 + 16'(i);
      tick();
    end
    cmd_valid_i = 1'b0;
    check("t2_full_count", fifo_count_o, 16);
    check("t2_full_ready", cmd_ready_o, 0);
    cmd_valid_i = 1'b1;
    cmd_brd_i   = 4'd7;
    cmd_addr_i  = 16'hBEEF;
    ok = 1'b1;
    n  = 0;
    while (!start_trig_o && n < 200) begin
      tick();
      if (fifo_count_o !== 5'd16) ok = 1'b0;
      n++;
    end
    cmd_valid_i = 1'b0;
    check("t2_window_start_seen", start_trig_o, 1);
    check("t2_count_held_at_full", ok, 1);
    wait_idle("t2_idle", 3000);
    tick();
    check("t2_dispatch_len", addr_q.size(), 18);
    for (int i = 0; i < 18; i++) begin
      if (i == 0)       exp_addr = 16'h0A00;
      else if (i == 17) exp_addr = 16'hBEEF;
      else              exp_addr = 16'h1000 + 16'(i - 1);
      got = (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hDEAD_DEAD;
      check($sformatf("t2_order_%0d", i), got, 32'(exp_addr));
    end
    check("t2_done_total", done_count_o, 20);

    // Reset mid-run clears queue, flags and counts without an abort
    check("t6_nack_sticky", nack_o, 1);
    check("t6_tmo_sticky", timeout_o, 1);
    run_len = 30;
    push(4'd2, 16'h0222);
    push(4'd3, 16'h0333);
    wait_start("t6_start");
    repeat (5) tick();
    check("t6_in_run_sel", sel_o, 4'd2);
    base_abort = n_abort;
    reset_i = 1'b1;
    tick();
    check("t6_sel", sel_o, 4'hF);
    check("t6_count", fifo_count_o, 0);
    check("t6_flags", {nack_o, timeout_o, awg_abort_o}, 0);
    check("t6_done", done_count_o, 0);
    check("t6_busy", busy_o, 0);
    reset_i = 1'b0;
    repeat (3) tick();
    check("t6_no_abort", n_abort - base_abort, 0);
    check("t6_sel_after", sel_o, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
